// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry issue buffer in front of the logical unit.
// It decodes incoming opcodes and issues them in acceptance order.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_op                 opcode: 0..3 are legal, all other values are illegal
//   in_src1, in_src2      operands
//   out_valid / out_ready downstream handshake
//   out_src1, out_src2    issued operands (head entry)
//   out_control           issued control word (head entry)
//   illegal_op            one-cycle pulse after an illegal opcode is consumed
//   err_count             saturating count of consumed illegal opcodes
module alu_issue_stage #(
  parameter int unsigned SRC_WIDTH     = 32,
  parameter int unsigned CONTROL_WIDTH = 11,
  parameter int unsigned OP_WIDTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_WIDTH-1:0]      in_op,
  input  logic [SRC_WIDTH-1:0]     in_src1,
  input  logic [SRC_WIDTH-1:0]     in_src2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SRC_WIDTH-1:0]     out_src1,
  output logic [SRC_WIDTH-1:0]     out_src2,
  output logic [CONTROL_WIDTH-1:0] out_control,
  output logic                     illegal_op,
  output logic [7:0]               err_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                   state_q, state_d;
  logic [SRC_WIDTH-1:0]     head_src1_q, head_src1_d;
  logic [SRC_WIDTH-1:0]     head_src2_q, head_src2_d;
  logic [CONTROL_WIDTH-1:0] head_ctrl_q, head_ctrl_d;
  logic [SRC_WIDTH-1:0]     skid_src1_q, skid_src1_d;
  logic [SRC_WIDTH-1:0]     skid_src2_q, skid_src2_d;
  logic [CONTROL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                     illegal_q, illegal_d;
  logic [7:0]               err_q, err_d;

  logic                     op_legal;
  logic [CONTROL_WIDTH-1:0] dec_ctrl;
  logic                     xfer_in, legal_in, illegal_in, xfer_out;

  // Both handshake outputs depend on registered state only.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);

  assign op_legal   = ((in_op >> 2) == '0);
  assign xfer_in    = in_valid && in_ready;
  assign legal_in   = xfer_in && op_legal;
  assign illegal_in = xfer_in && !op_legal;
  assign xfer_out   = out_valid && out_ready;

  // Decoded control: function select in [6:5], logical-unit enable in [0].
  always_comb begin
    dec_ctrl      = '0;
    dec_ctrl[6:5] = in_op[1:0];
    dec_ctrl[0]   = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    head_src1_d = head_src1_q;
    head_src2_d = head_src2_q;
    head_ctrl_d = head_ctrl_q;
    skid_src1_d = skid_src1_q;
    skid_src2_d = skid_src2_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      StEmpty: begin
        if (legal_in) begin
          state_d     = StOne;
          head_src1_d = in_src1;
          head_src2_d = in_src2;
          head_ctrl_d = dec_ctrl;
        end
      end
      StOne: begin
        if (legal_in && xfer_out) begin
          // Head leaves while the new entry takes its place.
          head_src1_d = in_src1;
          head_src2_d = in_src2;
          head_ctrl_d = dec_ctrl;
        end else if (legal_in) begin
          state_d     = StFull;
          skid_src1_d = in_src1;
          skid_src2_d = in_src2;
          skid_ctrl_d = dec_ctrl;
        end else if (xfer_out) begin
          // Head data is left in place so the outputs hold while empty.
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (xfer_out) begin
          state_d     = StOne;
          head_src1_d = skid_src1_q;
          head_src2_d = skid_src2_q;
          head_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    illegal_d = illegal_in;
    err_d     = err_q;
    if (illegal_in && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_src1_q <= '0;
      head_src2_q <= '0;
      head_ctrl_q <= '0;
      skid_src1_q <= '0;
      skid_src2_q <= '0;
      skid_ctrl_q <= '0;
      illegal_q   <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      head_src1_q <= head_src1_d;
      head_src2_q <= head_src2_d;
      head_ctrl_q <= head_ctrl_d;
      skid_src1_q <= skid_src1_d;
      skid_src2_q <= skid_src2_d;
      skid_ctrl_q <= skid_ctrl_d;
      illegal_q   <= illegal_d;
      err_q       <= err_d;
    end
  end

  assign out_src1    = head_src1_q;
  assign out_src2    = head_src2_q;
  assign out_control = head_ctrl_q;
  assign illegal_op  = illegal_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [10:0] out_control;
  logic        illegal_op;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_stage #(
    .SRC_WIDTH(32),
    .CONTROL_WIDTH(11),
    .OP_WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src1   (out_src1),
    .out_src2   (out_src2),
    .out_control(out_control),
    .illegal_op (illegal_op),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] s1,
                       input logic [31:0] s2);
    in_valid = v;
    in_op    = op;
    in_src1  = s1;
    in_src2  = s2;
  endtask

  logic [31:0] exp_src1 [2];
  logic [31:0] exp_ctrl [2];
  logic        pre_valid;
  logic [31:0] pre_src1, pre_src2, pre_ctrl;
  int          issued;

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ctrl", 32'(out_control), 32'd0);
    chk("rst_src1", out_src1, 32'd0);

    // Single AND op; first edge after release accepts it.
    #10;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'd1, 32'hF0F0F0F0, 32'h0FF00FF0);
    step();
    chk("and_valid", 32'(out_valid), 32'd1);
    chk("and_ctrl", 32'(out_control), 32'h021);
    chk("and_src1", out_src1, 32'hF0F0F0F0);
    chk("and_src2", out_src2, 32'h0FF00FF0);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    step();
    chk("and_empty", 32'(out_valid), 32'd0);
    chk("and_in_ready", 32'(in_ready), 32'd1);

    // Backpressure: XOR then OR fill both entries.
    out_ready = 1'b0;
    drive(1'b1, 4'd3, 32'd1, 32'd2);
    step();
    chk("bp_xor_valid", 32'(out_valid), 32'd1);
    chk("bp_xor_ctrl", 32'(out_control), 32'h061);
    chk("bp_one_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 4'd2, 32'd3, 32'd4);
    step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_ctrl", 32'(out_control), 32'h061);
    chk("bp_hold_src1", out_src1, 32'd1);
    drive(1'b1, 4'd1, 32'd9, 32'd9); // must not be taken while full
    step();
    chk("bp_hold2_ctrl", 32'(out_control), 32'h061);
    chk("bp_hold2_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_or_ctrl", 32'(out_control), 32'h041);
    chk("bp_or_src1", out_src1, 32'd3);
    chk("bp_or_src2", out_src2, 32'd4);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_empty_hold", 32'(out_control), 32'h041);

    // Streaming: one issue per cycle, stays in ONE.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i % 4), 32'(i), ~32'(i));
      step();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_ctrl", 32'(out_control), 32'h001 | (32'(i % 4) << 5));
      chk("st_src1", out_src1, 32'(i));
      chk("st_src2", out_src2, ~32'(i));
      chk("st_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    step();
    chk("st_drain", 32'(out_valid), 32'd0);

    // Illegal opcodes in EMPTY.
    drive(1'b1, 4'd9, 32'hDEAD, 32'hBEEF);
    step();
    chk("ill_no_valid", 32'(out_valid), 32'd0);
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_err1", 32'(err_count), 32'd1);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    step();
    chk("ill_pulse_end", 32'(illegal_op), 32'd0);
    chk("ill_err1_hold", 32'(err_count), 32'd1);
    drive(1'b1, 4'd9, 32'd0, 32'd0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 252) chk("ill_err254", 32'(err_count), 32'd254);
    end
    chk("ill_pulse_run", 32'(illegal_op), 32'd1);
    chk("ill_sat", 32'(err_count), 32'd255);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    step();
    chk("ill_sat_hold", 32'(err_count), 32'd255);
    chk("ill_never_valid", 32'(out_valid), 32'd0);

    // Illegal op while ONE leaves the entry alone.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'hAA, 32'hAB);
    step();
    drive(1'b1, 4'd15, 32'hCC, 32'hCD);
    step();
    chk("ill1_pulse", 32'(illegal_op), 32'd1);
    chk("ill1_still_one", 32'(in_ready), 32'd1);
    chk("ill1_src1", out_src1, 32'hAA);
    chk("ill1_ctrl", 32'(out_control), 32'h001);

    // Fill to FULL, then reset between edges.
    drive(1'b1, 4'd2, 32'hBB, 32'hBC);
    step();
    chk("full_before_rst", 32'(in_ready), 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_err", 32'(err_count), 32'd0);
    chk("arst_illegal", 32'(illegal_op), 32'd0);
    chk("arst_src1", out_src1, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 32'h55, 32'h66);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_ctrl", 32'(out_control), 32'h001);
    chk("post_rst_src1", out_src1, 32'h55);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    step();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    // FULL with random out_ready, upstream stalled.
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 32'h11, 32'h12);
    step();
    drive(1'b1, 4'd3, 32'h22, 32'h23);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    chk("rnd_full", 32'(in_ready), 32'd0);
    exp_src1[0] = 32'h11; exp_ctrl[0] = 32'h021;
    exp_src1[1] = 32'h22; exp_ctrl[1] = 32'h061;
    issued = 0;
    for (int c = 0; c < 40 && issued < 2; c++) begin
      out_ready = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      pre_valid = out_valid;
      pre_src1  = out_src1;
      pre_src2  = out_src2;
      pre_ctrl  = 32'(out_control);
      if (pre_valid && out_ready) begin
        chk("rnd_issue_src1", pre_src1, exp_src1[issued]);
        chk("rnd_issue_ctrl", pre_ctrl, exp_ctrl[issued]);
        issued++;
      end
      step();
      if (pre_valid && !out_ready) begin
        chk("rnd_stable_src1", out_src1, pre_src1);
        chk("rnd_stable_src2", out_src2, pre_src2);
        chk("rnd_stable_ctrl", 32'(out_control), pre_ctrl);
      end
    end
    chk("rnd_issued", 32'(issued), 32'd2);
    chk("rnd_empty", 32'(out_valid), 32'd0);
    chk("rnd_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter SRC_WIDTH, default 32, operand width in bits.
REQ-002 Parameter CONTROL_WIDTH, default 11, width of the emitted ALU control word.
REQ-003 Parameter OP_WIDTH, default 4, width of the incoming opcode.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  upstream presents an instruction.
REQ-007 Port in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 Port in_op  input  OP_WIDTH  opcode.
REQ-009 Port in_src1, in_src2  input  SRC_WIDTH each  operands.
REQ-010 Port out_valid  output  1  issued entry present toward the logical unit.
REQ-011 Port out_ready  input  1  downstream accepts the entry this cycle.
REQ-012 Port out_src1, out_src2  output  SRC_WIDTH each  issued operands.
REQ-013 Port out_control  output  CONTROL_WIDTH  issued control word.
REQ-014 Port illegal_op  output  1  one-cycle pulse: an illegal opcode was consumed last cycle.
REQ-015 Port err_count  output  8  saturating count of illegal opcodes consumed.

Function
REQ-016 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready; both evaluated at the rising edge.
REQ-017 Decode: op 0..3 legal; out_control[6:5] = op[1:0] (0 NOT, 1 AND, 2 OR, 3 XOR); out_control[0] = 1 (logical-unit enable); all other control bits 0.
REQ-018 Ops 4..15 illegal: consumed (handshake completes) but never enqueued or issued.
REQ-019 Storage: two entries, head (drives outputs) and skid; each holds src1, src2, decoded control.
REQ-020 States: EMPTY (0 entries), ONE (1), FULL (2), in a registered state register.
REQ-021 in_ready = 1 in EMPTY and ONE, 0 in FULL; purely a function of registered state, no combinational path from out_ready.
REQ-022 out_valid = 1 in ONE and FULL, 0 in EMPTY.
REQ-023 EMPTY + legal transfer in -> ONE, entry written to head; one-cycle latency, out_valid high the cycle after acceptance.
REQ-024 ONE + legal in, no out -> FULL, entry written to skid.
REQ-025 ONE + legal in + out -> ONE, new entry written to head.
REQ-026 ONE + out, no legal in -> EMPTY.
REQ-027 FULL + out -> ONE, skid moves to head; no input accepted in FULL.
REQ-028 Illegal op consumed in any state: state and stored entries change only as if no input occurred.
REQ-029 While out_valid && !out_ready, out_src1, out_src2, out_control SHALL hold stable.
REQ-030 Issue order SHALL equal acceptance order of legal ops; no entry duplicated or dropped.
REQ-031 illegal_op SHALL be 1 for exactly the cycle following each illegal consume, else 0.
REQ-032 err_count SHALL increment by 1 per illegal consume and saturate at 255 without wrapping.
REQ-033 Outputs while EMPTY: out_src1/out_src2/out_control hold last issued values (don't-care to downstream).

Reset
REQ-034 rst_n low SHALL immediately, regardless of clk, force state EMPTY, out_valid 0, in_ready 1, illegal_op 0, err_count 0, head/skid data 0.
REQ-035 Reset mid-operation SHALL discard all stored entries; no partial issue after release.
REQ-036 First transfer in SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-037 Single AND op, src1=0xF0F0F0F0, src2=0x0FF00FF0, out_ready=1 -> next cycle out_valid=1, out_control=0x021, operands unchanged; following cycle EMPTY.
REQ-038 out_ready=0, send XOR then OR -> in_ready low after second; out_control holds 0x061; raise out_ready -> 0x061 then 0x041 issued in order, in_ready high again.
REQ-039 Continuous in_valid and out_ready=1, ops 0,1,2,3 repeating -> one issue per cycle, controls 0x001,0x021,0x041,0x061, state stays ONE.
REQ-040 Op 9 in EMPTY -> no out_valid, illegal_op pulses one cycle, err_count=1; 300 illegal ops -> err_count=255.
REQ-041 FULL, assert rst_n=0 between edges -> out_valid=0, in_ready=1, err_count=0 immediately; after release, new NOT op issues with out_control=0x001.
REQ-042 FULL with out_ready toggling randomly while upstream stalled -> outputs stable whenever out_ready=0, both entries issued exactly once.
